// File: rtl/bus_pkg.sv
// Shared constants, state encoding and address decode for the bidding-arbiter bus.
// The arbiter and every slave responder import this package.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [15:0] ADDR_TAG = 16'hFFEF;
    localparam logic [3:0]  PAGE_NIB = 4'h2;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Address format FFEF_S2M0: tag, slave nibble, page nibble, word index, zero nibble.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [3:0] slave_id);
        return (addr[31:16] == ADDR_TAG) && (addr[15:12] == slave_id) &&
               (addr[11:8] == PAGE_NIB) && (addr[3:0] == 4'h0);
    endfunction

endpackage

// File: rtl/slv_mailbox.sv
// 16 x 32 mailbox register file: one synchronous write port, one combinational read port.
module slv_mailbox #(
    parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  raddr_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem_q [16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= RESET_DATA;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_slave_resp.sv
// Slave-side responder: captures one bus transfer, waits WAIT_STATES cycles,
// then answers with a single registered ack (plus err on a decode miss).
module bus_slave_resp
    import bus_pkg::*;
#(
    parameter int unsigned SLAVE_ID    = 0,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] RESET_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] DataToSlave,
    output logic [31:0] DataFromSlave,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam logic [3:0] SID = 4'(SLAVE_ID);
    localparam logic [3:0] WS  = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic        mb_we;
    logic [31:0] mb_rdata;

    assign hit = addr_hit(addr_q, SID);

    slv_mailbox #(.RESET_DATA(RESET_DATA)) u_mailbox (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mb_we),
        .waddr_i (addr_q[7:4]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[7:4]),
        .rdata_o (mb_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        mb_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    wdata_d = DataToSlave;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Losing sel mid-wait abandons the transfer silently.
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                // Response is registered here so ack/err/data appear on the following cycle.
                ack_d   = 1'b1;
                state_d = DONE;
                if (!hit) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else if (rw_q) begin
                    mb_we   = 1'b1;
                    rdata_d = wdata_q;
                end else begin
                    rdata_d = mb_rdata;
                end
            end
            DONE: begin
                if (!sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack           = ack_q;
    assign err           = err_q;
    assign DataFromSlave = rdata_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bus_slave_resp.sv
// Bench for bus_slave_resp: three instances with different SLAVE_ID / WAIT_STATES /
// RESET_DATA, a transaction-level mailbox model, and a per-cycle output checker.
module tb_bus_slave_resp;

    localparam int          N = 3;
    localparam int          SID_T [N] = '{2, 1, 0};
    localparam int          WS_T  [N] = '{2, 3, 0};
    localparam logic [31:0] RST_T [N] = '{32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000};

    logic        clk;
    logic        rst;
    logic [N-1:0] sel;
    logic [N-1:0] rw;
    logic [31:0] addr [N];
    logic [31:0] dts  [N];
    logic [31:0] dfs  [N];
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [N-1:0] busy;
    logic [1:0]  dbg  [N];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: mailbox contents and the cycle at which each instance must ack.
    logic [31:0] mem_m [N][16];
    int          exp_cyc [N];
    logic        exp_err [N];
    logic [31:0] exp_data [N];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_slave_resp #(.SLAVE_ID(2), .WAIT_STATES(2), .RESET_DATA(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel[0]), .rw(rw[0]), .addr(addr[0]), .DataToSlave(dts[0]),
        .DataFromSlave(dfs[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]), .dbg_state_o(dbg[0])
    );
    bus_slave_resp #(.SLAVE_ID(1), .WAIT_STATES(3), .RESET_DATA(32'h0000_0000)) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel[1]), .rw(rw[1]), .addr(addr[1]), .DataToSlave(dts[1]),
        .DataFromSlave(dfs[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]), .dbg_state_o(dbg[1])
    );
    bus_slave_resp #(.SLAVE_ID(0), .WAIT_STATES(0), .RESET_DATA(32'hA5A5_0000)) u_dut2 (
        .clk(clk), .rst(rst), .sel(sel[2]), .rw(rw[2]), .addr(addr[2]), .DataToSlave(dts[2]),
        .DataFromSlave(dfs[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]), .dbg_state_o(dbg[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a, input int sid);
        logic [3:0] s;
        s = 4'(sid);
        return (a[31:16] == 16'hFFEF) && (a[15:12] == s) && (a[11:8] == 4'h2) && (a[3:0] == 4'h0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            exp_cyc[k] = -1;
            for (int w = 0; w < 16; w++) mem_m[k][w] = RST_T[k];
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic ea;
            ea = (cyc == exp_cyc[k]);
            check($sformatf("ack%0d", k), {31'd0, ack[k]}, {31'd0, ea});
            check($sformatf("err%0d", k), {31'd0, err[k]}, {31'd0, ea && exp_err[k]});
            check($sformatf("data%0d", k), dfs[k], ea ? exp_data[k] : 32'h0);
        end
    end

    // ---------------- driver ----------------
    // One full transfer on instance k; sel is held 'hold' extra cycles after ack.
    task automatic do_xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int hold, output int lat, output logic g_err, output logic [31:0] g_data);
        int  c0;
        bit  seen;
        @(negedge clk);
        sel[k] = 1'b1; rw[k] = w; addr[k] = a; dts[k] = d;
        c0 = cyc;
        exp_cyc[k] = c0 + 2 + WS_T[k];
        if (!model_hit(a, SID_T[k])) begin
            exp_err[k] = 1'b1; exp_data[k] = 32'hDEAD_BEEF;
        end else if (w) begin
            exp_err[k] = 1'b0; exp_data[k] = d; mem_m[k][a[7:4]] = d;
        end else begin
            exp_err[k] = 1'b0; exp_data[k] = mem_m[k][a[7:4]];
        end
        seen = 0; lat = -1; g_err = 1'bx; g_data = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                addr[k] = $urandom; dts[k] = $urandom; rw[k] = ~w;
            end
            if (ack[k]) begin
                seen = 1; lat = cyc - (c0 + 1); g_err = err[k]; g_data = dfs[k];
                break;
            end
        end
        if (!seen) check($sformatf("timeout%0d", k), 32'd0, 32'd1);
        repeat (hold) @(negedge clk);
        sel[k] = 1'b0;
    endtask

    int          lat;
    logic        g_err;
    logic [31:0] g_data;

    initial begin
        rst = 1'b0;
        sel = '0; rw = '0;
        for (int k = 0; k < N; k++) begin
            addr[k] = '0; dts[k] = '0; exp_err[k] = 0; exp_data[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, ack[0]}, 32'd0);
        check("rst_busy", {29'd0, busy}, 32'd0);
        check("rst_state", {30'd0, dbg[0]}, 32'd0);
        rst = 1'b1;

        // Write then read on SLAVE_ID=2, WAIT_STATES=2.
        do_xfer(0, 1'b1, 32'hFFEF_2210, 32'hCAFE_0001, 0, lat, g_err, g_data);
        check("wr_latency", lat, 32'd3);
        check("wr_err", {31'd0, g_err}, 32'd0);
        check("wr_echo", g_data, 32'hCAFE_0001);
        do_xfer(0, 1'b0, 32'hFFEF_2210, 32'h0, 0, lat, g_err, g_data);
        check("rd_data", g_data, 32'hCAFE_0001);

        // Decode errors: wrong slave nibble, nonzero low nibble.
        do_xfer(0, 1'b1, 32'hFFEF_1210, 32'h1111_1111, 0, lat, g_err, g_data);
        check("miss_slave_err", {31'd0, g_err}, 32'd1);
        check("miss_slave_data", g_data, 32'hDEAD_BEEF);
        do_xfer(0, 1'b1, 32'hFFEF_2214, 32'h2222_2222, 0, lat, g_err, g_data);
        check("miss_low_err", {31'd0, g_err}, 32'd1);
        do_xfer(0, 1'b0, 32'hFFEF_2210, 32'h0, 0, lat, g_err, g_data);
        check("word1_kept", g_data, 32'hCAFE_0001);

        // Held sel: one ack only, busy stays until sel drops.
        do_xfer(0, 1'b1, 32'hFFEF_2220, 32'h1111_2222, 6, lat, g_err, g_data);
        check("held_busy", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        check("held_idle", {31'd0, busy[0]}, 32'd0);
        do_xfer(0, 1'b0, 32'hFFEF_2220, 32'h0, 0, lat, g_err, g_data);
        check("held_rd", g_data, 32'h1111_2222);

        // Abort during WAIT on WAIT_STATES=3.
        do_xfer(1, 1'b1, 32'hFFEF_1230, 32'h0000_7777, 0, lat, g_err, g_data);
        check("wr1_latency", lat, 32'd4);
        @(negedge clk);
        sel[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'hFFEF_1250; dts[1] = 32'h5555_5555;
        @(negedge clk);
        check("abort_busy", {31'd0, busy[1]}, 32'd1);
        sel[1] = 1'b0;
        @(negedge clk);
        check("abort_idle", {31'd0, busy[1]}, 32'd0);
        do_xfer(1, 1'b0, 32'hFFEF_1250, 32'h0, 0, lat, g_err, g_data);
        check("abort_nowrite", g_data, 32'h0000_0000);

        // Reset held mid-WAIT: transfer aborted and mailboxes cleared.
        @(negedge clk);
        sel[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'hFFEF_1230; dts[1] = 32'h9999_9999;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sel[1] = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy[1]}, 32'd0);
        check("mid_rst_ack", {31'd0, ack[1]}, 32'd0);
        check("mid_rst_data", dfs[1], 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_xfer(1, 1'b0, 32'hFFEF_1230, 32'h0, 0, lat, g_err, g_data);
        check("post_rst_w3", g_data, 32'h0000_0000);
        do_xfer(0, 1'b0, 32'hFFEF_2210, 32'h0, 0, lat, g_err, g_data);
        check("post_rst_w1", g_data, 32'h0000_0000);

        // Zero wait states, SLAVE_ID=0, back-to-back with one-cycle sel gaps.
        do_xfer(2, 1'b1, 32'hFFEF_0230, 32'h0000_3333, 0, lat, g_err, g_data);
        check("zw_wr_latency", lat, 32'd1);
        do_xfer(2, 1'b0, 32'hFFEF_0200, 32'h0, 0, lat, g_err, g_data);
        check("zw_rd0", g_data, 32'hA5A5_0000);
        check("zw_rd0_latency", lat, 32'd1);
        do_xfer(2, 1'b0, 32'hFFEF_0230, 32'h0, 0, lat, g_err, g_data);
        check("zw_rd3", g_data, 32'h0000_3333);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
